// File: rtl/fetch_stage.sv
// fetch_stage: pipeline stage 1. Owns the PC, drives the instruction-memory
// address and registers the fetched instruction into the IF/ID register.
// Sequences boot, load-use stall, branch flush and halt.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall/flush cycle
// counter on output stall_cnt.
module fetch_stage #(
    parameter int unsigned        PC_W        = 8,
    parameter int unsigned        INSTR_W     = 16,
    parameter logic [PC_W-1:0]    RESET_PC    = 8'h00,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]         HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard,
    input  logic [PC_W-1:0]    new_pc,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               halted
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    ifid_pc_q;
    logic               valid_q;
    logic               halted_q;
    logic               halt_fetch;

    // Opcode field of the word currently being fetched matches the halt opcode
    assign halt_fetch = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

    // PC, IF/ID register and sequencing state; branch beats hazard beats fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    instr_q  <= NOP_INSTR;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                    state_q  <= S_RUN;
                end
                S_RUN, S_STALL: begin
                    if (branch_taken) begin
                        pc_q    <= branch_target;
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        state_q <= S_RUN;
                    end else if (hazard && valid_q) begin
                        // Hold IF/ID; refetch from the hazard unit's PC
                        pc_q    <= new_pc;
                        state_q <= S_STALL;
                    end else begin
                        instr_q   <= imem_data;
                        ifid_pc_q <= pc_q;
                        valid_q   <= 1'b1;
                        if (halt_fetch) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q    <= pc_q + PC_W'(1);
                            state_q <= S_RUN;
                        end
                    end
                end
                S_HALT: begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (branch_taken) begin
                        // Halt was fetched on a wrong path
                        pc_q     <= branch_target;
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;

    // A cycle counts if spent in stall or if a branch flushes IF/ID
    assign cnt_inc = (state_q == S_STALL) || (branch_taken && (state_q != S_BOOT));

    // Saturating stall/flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`endif

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus steps a behavioural model and
// queues the expected post-edge outputs; a monitor compares after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard = 1'b0;
    logic [7:0]  new_pc = '0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .new_pc        (new_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  ipc;
        logic        valid;
        logic        halted;
        logic [7:0]  addr;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    int unsigned m_pc = 0;
    logic [15:0] m_instr = '0;
    int unsigned m_ipc = 0;
    bit          m_valid = 0;
    bit          m_halt = 0;
    bit          m_boot = 1;
    bit          m_in_stall = 0;
    int unsigned m_cnt = 0;

    task automatic model_step(input bit r, input bit h, input logic [7:0] np,
                              input bit b, input logic [7:0] bt);
        bit inc;
        inc = 0;
        if (r) begin
            m_pc = 0; m_instr = '0; m_ipc = 0; m_valid = 0;
            m_halt = 0; m_boot = 1; m_in_stall = 0; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_instr = '0;
            m_valid = 0;
            if (b) begin
                inc = 1;
                m_pc = bt;
                m_halt = 0;
            end
        end else begin
            inc = m_in_stall || b;
            if (b) begin
                m_pc = bt; m_instr = '0; m_valid = 0; m_in_stall = 0;
            end else if (h && m_valid) begin
                m_pc = np; m_in_stall = 1;
            end else begin
                m_instr = mem[m_pc];
                m_ipc = m_pc;
                m_valid = 1;
                m_in_stall = 0;
                if (m_instr[15:12] == 4'hF) m_halt = 1;
                else m_pc = (m_pc + 1) % 256;
            end
        end
        if (inc && m_cnt < 65535) m_cnt = m_cnt + 1;
    endtask

    task automatic cyc(input bit r, input bit h, input logic [7:0] np,
                       input bit b, input logic [7:0] bt);
        exp_t e;
        @(negedge clk);
        rst = r; hazard = h; new_pc = np; branch_taken = b; branch_target = bt;
        model_step(r, h, np, b, bt);
        e.instr = m_instr; e.ipc = 8'(m_ipc); e.valid = m_valid;
        e.halted = m_halt; e.addr = 8'(m_pc); e.cnt = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs just after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc", 16'(if_id_pc), 16'(e.ipc));
                chk("if_id_valid", 16'(if_id_valid), 16'(e.valid));
                chk("halted", 16'(halted), 16'(e.halted));
                chk("imem_addr", 16'(imem_addr), 16'(e.addr));
`ifdef FETCH_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);

        // Reset then straight-line fetch
        cyc(1, 0, 8'h00, 0, 8'h00);
        cyc(1, 0, 8'h00, 0, 8'h00);
        run(6);                               // boot, then pc 0..4 -> pc=5
        // Load-use stall at pc=5
        cyc(0, 1, 8'h05, 0, 8'h00);
        cyc(0, 1, 8'h05, 0, 8'h00);
        run(3);
        // Branch with simultaneous hazard
        cyc(0, 1, 8'h22, 1, 8'h40);
        run(3);
        // PC wrap
        cyc(0, 0, 8'h00, 1, 8'hFE);
        run(4);
        // Halt at pc=3, hazard ignored while halted, branch out
        cyc(0, 0, 8'h00, 1, 8'h00);
        mem[3] = 16'hF000;
        run(6);
        cyc(0, 1, 8'h07, 0, 8'h00);
        cyc(0, 1, 8'h07, 0, 8'h00);
        cyc(0, 0, 8'h00, 1, 8'h10);
        run(3);
        // Halt again, then reset mid-halt
        cyc(0, 0, 8'h00, 1, 8'h00);
        run(6);
        cyc(1, 0, 8'h00, 0, 8'h00);
        mem[3] = 16'h0103;
        run(3);

`ifdef FETCH_STALL_CNT_EN
        // Three hazard cycles plus one branch, then saturation
        cyc(1, 0, 8'h00, 0, 8'h00);
        run(3);
        cyc(0, 1, 8'h02, 0, 8'h00);
        cyc(0, 1, 8'h02, 0, 8'h00);
        cyc(0, 1, 8'h02, 0, 8'h00);
        run(2);
        cyc(0, 0, 8'h00, 1, 8'h20);
        run(2);
        for (int i = 0; i < 65540; i++) cyc(0, 1, 8'h22, 0, 8'h00);
        run(2);
`endif

        // Randomized traffic over random memory
        cyc(1, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'hF && ($urandom_range(0, 7) != 0)) mem[i][15:12] = 4'hE;
        end
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 7) == 0, 8'($urandom));
        end
        run(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
